// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared register offsets, FSM state type and default MMIO window base.
package mem_ctrl_pkg;
    localparam logic [31:0] OUT_OFS = 32'h0;
    localparam logic [31:0] CYC_OFS = 32'h4;
    localparam logic [31:0] STAT_OFS = 32'h8;
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h0000_1000;
    typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/mem_ram.sv
// mem_ram: single-port synchronous-read RAM, write-first, contents never reset.
module mem_ram #(
    parameter int WORDS = 256,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: word-addressed bus to data RAM plus OUT/CYC/STAT register window.
// Reads answer one cycle after acceptance; writes commit at the request edge.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic [15:0] data_out
);
    localparam int AW = $clog2(RAM_WORDS);
    state_t state, next_state;
    logic [31:0] cyc, reg_q, reg_val, ram_q;
    logic wr_seen, sel_ram, is_ram, is_out, is_cyc, is_stat, do_wr, do_rd;
    logic unused;
    assign unused = &{1'b0, mem_addr[1:0]};
    assign is_ram = mem_addr[31:AW+2] == '0;
    assign is_out = mem_addr[31:2] == (MMIO_BASE[31:2] + OUT_OFS[31:2]);
    assign is_cyc = mem_addr[31:2] == (MMIO_BASE[31:2] + CYC_OFS[31:2]);
    assign is_stat = mem_addr[31:2] == (MMIO_BASE[31:2] + STAT_OFS[31:2]);
    assign do_wr = state == IDLE && mem_we;
    assign do_rd = state == IDLE && mem_re && !mem_we;
    assign reg_val = is_out ? {16'h0, data_out} :
                     is_cyc ? cyc :
                     is_stat ? {30'h0, wr_seen, 1'b1} : 32'h0;
    mem_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk(clk),
        .en(do_rd || (do_wr && is_ram)),
        .we(do_wr && is_ram),
        .addr(mem_addr[AW+1:2]),
        .wdata(mem_data),
        .rdata(ram_q)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cyc <= 32'h0;
            data_out <= 16'h0;
            wr_seen <= 1'b0;
            sel_ram <= 1'b0;
            reg_q <= 32'h0;
        end else begin
            state <= next_state;
            cyc <= cyc + 32'd1;
            if (do_wr && is_out) begin
                data_out <= mem_data[15:0];
                wr_seen <= 1'b1;
            end
            if (do_rd) begin
                sel_ram <= is_ram;
                reg_q <= reg_val;
            end
        end
    end
    // RESP always lasts exactly one cycle, so rvalid is just the state decode
    always_comb begin
        next_state = IDLE;
        busy = 1'b0;
        rvalid = 1'b0;
        rdata = 32'h0;
        if (state == IDLE) begin
            next_state = do_rd ? RESP : IDLE;
        end else begin
            busy = 1'b1;
            rvalid = 1'b1;
            rdata = sel_ram ? ram_q : reg_q;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of RAM, register window, FSM handshake and reset.
module tb_mem_ctrl;
    localparam logic [31:0] BASE = 32'h0000_1000;
    logic clk, rst_n, mem_we, mem_re, rvalid, busy;
    logic [31:0] mem_addr, mem_data, rdata, v, v2;
    logic [15:0] data_out;
    int errors = 0;
    int checks = 0;

    mem_ctrl #(.RAM_WORDS(256), .MMIO_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_re(mem_re), .rdata(rdata), .rvalid(rvalid),
        .busy(busy), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the return-to-IDLE edge.
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        mem_addr = a;
        mem_re = 1'b1;
        mem_we = 1'b0;
        @(negedge clk);
        chk("rd_rvalid", {31'h0, rvalid}, 32'h1);
        chk("rd_busy", {31'h0, busy}, 32'h1);
        d = rdata;
        mem_re = 1'b0;
        @(negedge clk);
        chk("rd_rvalid_drop", {31'h0, rvalid}, 32'h0);
        chk("rd_rdata_zero", rdata, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr = a;
        mem_data = d;
        mem_we = 1'b1;
        mem_re = 1'b0;
        @(negedge clk);
        mem_we = 1'b0;
        chk("wr_no_rvalid", {31'h0, rvalid}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        mem_addr = 32'h0;
        mem_data = 32'h0;
        #1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_rvalid", {31'h0, rvalid}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_data_out", {16'h0, data_out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        rd(BASE + 32'h8, v);
        chk("stat_after_reset", v, 32'h1);

        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, v);
        chk("ram_deadbeef", v, 32'hDEAD_BEEF);
        wr(32'h0, 32'h0000_0A0A);
        wr(32'h13, 32'h7777_0001);
        rd(32'h10, v);
        chk("ram_byte_offset_ignored", v, 32'h7777_0001);
        rd(32'h0, v);
        chk("ram_word0", v, 32'h0000_0A0A);

        wr(BASE, 32'h1234_ABCD);
        chk("data_out_abcd", {16'h0, data_out}, 32'h0000_ABCD);
        rd(BASE + 32'h8, v);
        chk("stat_wr_seen", v, 32'h3);
        rd(BASE, v);
        chk("out_readback", v, 32'h0000_ABCD);

        wr(BASE + 32'h4, 32'h0);
        rd(BASE + 32'h4, v);
        repeat (8) @(negedge clk);
        rd(BASE + 32'h4, v2);
        chk("cyc_delta_10", v2 - v, 32'd10);

        force dut.cyc = 32'hFFFF_FFFF;
        mem_addr = BASE + 32'h4;
        mem_re = 1'b1;
        @(posedge clk);
        #1 release dut.cyc;
        @(negedge clk);
        chk("cyc_forced_max", rdata, 32'hFFFF_FFFF);
        mem_re = 1'b0;
        @(negedge clk);
        rd(BASE + 32'h4, v);
        chk("cyc_wrapped_small", {31'h0, v < 32'd8}, 32'h1);

        mem_addr = 32'h20;
        mem_data = 32'h5;
        mem_we = 1'b1;
        mem_re = 1'b1;
        @(negedge clk);
        mem_we = 1'b0;
        mem_re = 1'b0;
        chk("we_re_no_rvalid", {31'h0, rvalid}, 32'h0);
        chk("we_re_no_busy", {31'h0, busy}, 32'h0);
        rd(32'h20, v);
        chk("we_re_wrote", v, 32'h5);

        mem_addr = 32'h20;
        mem_re = 1'b1;
        @(negedge clk);
        chk("resp_rdata", rdata, 32'h5);
        mem_re = 1'b0;
        mem_we = 1'b1;
        mem_data = 32'h99;
        @(negedge clk);
        mem_we = 1'b0;
        mem_addr = BASE;
        mem_data = 32'h0000_5555;
        mem_re = 1'b1;
        @(negedge clk);
        mem_addr = BASE;
        mem_re = 1'b0;
        mem_we = 1'b1;
        @(negedge clk);
        mem_we = 1'b0;
        rd(32'h20, v);
        chk("resp_write_ignored", v, 32'h5);
        chk("resp_out_write_ignored", {16'h0, data_out}, 32'h0000_ABCD);

        rd(32'h8000_0000, v);
        chk("unmapped_read", v, 32'h0);
        wr(32'h8000_0000, 32'hCAFE_F00D);
        rd(32'h0, v);
        chk("unmapped_wr_ram", v, 32'h0000_0A0A);
        rd(BASE, v);
        chk("unmapped_wr_out", v, 32'h0000_ABCD);

        wr(32'h40, 32'h0BAD_C0DE);
        rd(32'h40, v);
        chk("raw_consecutive", v, 32'h0BAD_C0DE);

        mem_addr = 32'h10;
        mem_re = 1'b1;
        @(negedge clk);
        chk("pre_reset_rvalid", {31'h0, rvalid}, 32'h1);
        mem_re = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rvalid", {31'h0, rvalid}, 32'h0);
        chk("async_busy", {31'h0, busy}, 32'h0);
        chk("async_rdata", rdata, 32'h0);
        chk("async_data_out", {16'h0, data_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(BASE + 32'h4, v);
        chk("cyc_after_reset", v, 32'h0);
        rd(BASE + 32'h8, v);
        chk("stat_cleared", v, 32'h1);
        rd(32'h10, v);
        chk("ram_survives_reset", v, 32'h7777_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
